// File: rtl/ts_packet_mux_if.sv
// Muxed transport-stream output bundle.
// Master drives the byte stream, slave observes it.
interface ts_packet_mux_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] ts_data;
  logic                  ts_valid;
  logic                  ts_sop;
  logic                  ts_eop;
  logic [1:0]            ts_chan;

  modport master (
    output ts_data,
    output ts_valid,
    output ts_sop,
    output ts_eop,
    output ts_chan
  );

  modport slave (
    input ts_data,
    input ts_valid,
    input ts_sop,
    input ts_eop,
    input ts_chan
  );
endinterface

// File: rtl/ts_packet_mux.sv
// Four-channel TS packet aligner with ping-pong buffers and
// a round-robin packet multiplexer onto one output stream.
module ts_packet_mux #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(8'h47)
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic [DATA_WIDTH-1:0] rdata3,
  input  logic [DATA_WIDTH-1:0] rdata4,
  input  logic                  valid_in1,
  input  logic                  valid_in2,
  input  logic                  valid_in3,
  input  logic                  valid_in4,
  ts_packet_mux_if.master       ts,
  output logic [3:0]            sync_lock,
  output logic [3:0]            sync_loss,
  output logic [3:0]            drop_pkt
);

  localparam int IW = $clog2(PKT_LEN);
  localparam int AW = $clog2(2 * PKT_LEN);

  typedef logic [IW-1:0] idx_t;
  typedef logic [AW-1:0] addr_t;

  localparam idx_t LAST = idx_t'(PKT_LEN - 1);

  typedef enum logic {
    HUNT,
    CAPTURE
  } ch_st_e;

  typedef enum logic {
    IDLE,
    SEND
  } arb_st_e;

  function automatic addr_t slot_base(input logic s);
    return s ? addr_t'(PKT_LEN) : '0;
  endfunction

  logic [DATA_WIDTH-1:0] din [4];
  logic [3:0]            vin;

  assign din[0] = rdata1;
  assign din[1] = rdata2;
  assign din[2] = rdata3;
  assign din[3] = rdata4;
  assign vin    = {valid_in4, valid_in3,
                   valid_in2, valid_in1};

  // Two packet slots per channel, slot s at s*PKT_LEN
  logic [DATA_WIDTH-1:0] mem_q [4][2*PKT_LEN];

  ch_st_e     st_q    [4];
  ch_st_e     st_d    [4];
  idx_t       idx_q   [4];
  idx_t       idx_d   [4];
  logic [1:0] cnt_q   [4];
  logic [1:0] cnt_d   [4];
  addr_t      waddr   [4];
  logic [3:0] wslot_q, wslot_d;
  logic [3:0] rslot_q, rslot_d;
  logic [3:0] drop_q, drop_d;
  logic [3:0] dnow;
  logic [3:0] loss_q, loss_d;
  logic [3:0] dpkt_q, dpkt_d;
  logic [3:0] we;
  logic [3:0] commit;
  logic [3:0] rel;

  arb_st_e    arb_q, arb_d;
  logic [1:0] gch_q, gch_d;
  logic [1:0] last_q, last_d;
  idx_t       ridx_q, ridx_d;
  logic       found;
  logic [1:0] cand;

  logic [DATA_WIDTH-1:0] ts_data_q;
  logic                  ts_valid_q;
  logic                  ts_sop_q;
  logic                  ts_eop_q;
  logic [1:0]            ts_chan_q;
  addr_t                 raddr;
  logic [DATA_WIDTH-1:0] rd_byte;

  always_comb begin
    rel = '0;
    if (arb_q == SEND && ridx_q == LAST) begin
      rel[gch_q] = 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      st_d[c]    = st_q[c];
      idx_d[c]   = idx_q[c];
      cnt_d[c]   = cnt_q[c];
      wslot_d[c] = wslot_q[c];
      rslot_d[c] = rslot_q[c];
      drop_d[c]  = drop_q[c];
      dnow[c]    = drop_q[c];
      loss_d[c]  = 1'b0;
      dpkt_d[c]  = 1'b0;
      we[c]      = 1'b0;
      commit[c]  = 1'b0;
      waddr[c]   = slot_base(wslot_q[c])
                 + addr_t'(idx_q[c]);
      if (vin[c]) begin
        unique case (st_q[c])
          HUNT: begin
            if (din[c] == SYNC_BYTE) begin
              st_d[c]   = CAPTURE;
              idx_d[c]  = idx_t'(1);
              dnow[c]   = (cnt_q[c] == 2'd2);
              drop_d[c] = dnow[c];
              we[c]     = !dnow[c];
            end
          end
          CAPTURE: begin
            if (idx_q[c] == '0 &&
                din[c] != SYNC_BYTE) begin
              st_d[c]   = HUNT;
              loss_d[c] = 1'b1;
            end else begin
              // Drop decision is latched at the sync byte
              if (idx_q[c] == '0) begin
                dnow[c] = (cnt_q[c] == 2'd2);
              end
              drop_d[c] = dnow[c];
              we[c]     = !dnow[c];
              if (idx_q[c] == LAST) begin
                idx_d[c] = '0;
                if (dnow[c]) begin
                  dpkt_d[c] = 1'b1;
                end else begin
                  commit[c]  = 1'b1;
                  wslot_d[c] = ~wslot_q[c];
                end
              end else begin
                idx_d[c] = idx_q[c] + idx_t'(1);
              end
            end
          end
          default: ;
        endcase
      end
      if (rel[c]) begin
        rslot_d[c] = ~rslot_q[c];
      end
      unique case ({commit[c], rel[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 2'd1;
        2'b01:   cnt_d[c] = cnt_q[c] - 2'd1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int c = 0; c < 4; c++) begin
        st_q[c]  <= HUNT;
        idx_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      wslot_q <= '0;
      rslot_q <= '0;
      drop_q  <= '0;
      loss_q  <= '0;
      dpkt_q  <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        st_q[c]  <= st_d[c];
        idx_q[c] <= idx_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      wslot_q <= wslot_d;
      rslot_q <= rslot_d;
      drop_q  <= drop_d;
      loss_q  <= loss_d;
      dpkt_q  <= dpkt_d;
    end
  end

  always_ff @(posedge rclk) begin
    for (int c = 0; c < 4; c++) begin
      if (we[c]) begin
        mem_q[c][waddr[c]] <= din[c];
      end
    end
  end

  always_comb begin
    arb_d  = arb_q;
    gch_d  = gch_q;
    last_d = last_q;
    ridx_d = ridx_q;
    found  = 1'b0;
    cand   = '0;
    unique case (arb_q)
      IDLE: begin
        // Search starts just after the last granted channel
        for (int k = 1; k <= 4; k++) begin
          cand = last_q + 2'(k);
          if (!found && cnt_q[cand] != 2'd0) begin
            found  = 1'b1;
            gch_d  = cand;
            last_d = cand;
            ridx_d = '0;
            arb_d  = SEND;
          end
        end
      end
      SEND: begin
        if (ridx_q == LAST) begin
          arb_d = IDLE;
        end else begin
          ridx_d = ridx_q + idx_t'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      arb_q  <= IDLE;
      gch_q  <= '0;
      last_q <= 2'd3;
      ridx_q <= '0;
    end else begin
      arb_q  <= arb_d;
      gch_q  <= gch_d;
      last_q <= last_d;
      ridx_q <= ridx_d;
    end
  end

  assign raddr   = slot_base(rslot_q[gch_q])
                 + addr_t'(ridx_q);
  assign rd_byte = mem_q[gch_q][raddr];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      ts_data_q  <= '0;
      ts_valid_q <= 1'b0;
      ts_sop_q   <= 1'b0;
      ts_eop_q   <= 1'b0;
      ts_chan_q  <= '0;
    end else begin
      ts_valid_q <= (arb_q == SEND);
      ts_sop_q   <= (arb_q == SEND) && (ridx_q == '0);
      ts_eop_q   <= (arb_q == SEND) && (ridx_q == LAST);
      if (arb_q == SEND) begin
        ts_data_q <= rd_byte;
        ts_chan_q <= gch_q;
      end
    end
  end

  assign ts.ts_data  = ts_data_q;
  assign ts.ts_valid = ts_valid_q;
  assign ts.ts_sop   = ts_sop_q;
  assign ts.ts_eop   = ts_eop_q;
  assign ts.ts_chan  = ts_chan_q;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      sync_lock[c] = (st_q[c] == CAPTURE);
    end
  end

  assign sync_loss = loss_q;
  assign drop_pkt  = dpkt_q;

endmodule
